// File: rtl/jtcop_pkg.sv
// Shared definitions for the DECO object-RAM DMA path.
// The sprite engine and benches use these to decode the DMA state and to
// know how many words a copy moves.
package jtcop_pkg;

    // Default word-address width and resulting copy length
    localparam int OBJDMA_AW  = 10;
    localparam int OBJDMA_LEN = 1 << OBJDMA_AW;

    // DMA state encodings
    localparam logic [1:0] OBJDMA_ST_IDLE = 2'd0;
    localparam logic [1:0] OBJDMA_ST_PEND = 2'd1;
    localparam logic [1:0] OBJDMA_ST_COPY = 2'd2;
    localparam logic [1:0] OBJDMA_ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = OBJDMA_ST_IDLE,
        ST_PEND = OBJDMA_ST_PEND,
        ST_COPY = OBJDMA_ST_COPY,
        ST_DONE = OBJDMA_ST_DONE
    } objdma_st_t;

endpackage

// File: rtl/jtcop_objdma.sv
// Object-RAM DMA controller (main-CPU side of the DECO video board).
// A rising edge on obj_copy requests a copy of the 2^AW-word object RAM
// into bank mixpsel of the object buffer. The single RAM read port is
// owned by the DMA during COPY and by the CPU otherwise; a CPU access
// that collides with a copy is stalled through cpu_busy.
//
// Build option: JTCOP_OBJDMA_VBLANK_EN - when defined, a pending request
// waits for vertical blank (LVBL low) before copying; when undefined the
// copy starts the cycle after the request is accepted.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   LVBL                vertical blank, active low
//   obj_copy            CPU *DM strobe (edge detected internally)
//   mixpsel             destination bank, latched at copy start
//   cpu_cs, cpu_addr    CPU access to object RAM
//   cpu_busy            stall request to DTACK logic
//   src_addr, src_dout  shared object-RAM read port (1-cycle latency)
//   dst_addr/din/we     object buffer write port, address {bank, index}
//   dma_busy, dma_done  status: busy until last write, done pulse
module jtcop_objdma
    import jtcop_pkg::*;
#(
    parameter int AW = OBJDMA_AW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          obj_copy,
    input  logic          mixpsel,
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_busy,
    output logic [AW-1:0] src_addr,
    input  logic [15:0]   src_dout,
    output logic [AW:0]   dst_addr,
    output logic [15:0]   dst_din,
    output logic          dst_we,
    output logic          dma_busy,
    output logic          dma_done
);

    objdma_st_t    st, st_nx;
    logic          copy_l;
    logic          req;
    logic          go;
    logic          rearm;
    logic          bank;
    logic          hold;
    logic [AW:0]   idx;     // MSB set = all words issued, flush cycle

    assign req = obj_copy & ~copy_l;

`ifdef JTCOP_OBJDMA_VBLANK_EN
    assign go = ~LVBL;
`else
    // LVBL is ignored in this build; OR keeps the port referenced
    assign go = 1'b1 | LVBL;
`endif

    always_comb begin
        st_nx = st;
        case (st)
            ST_IDLE: if (req) st_nx = ST_PEND;
            ST_PEND: if (go)  st_nx = ST_COPY;
            ST_COPY: if (idx[AW]) st_nx = ST_DONE;
            // an edge landing on DONE itself is folded in here
            ST_DONE: st_nx = (rearm || req) ? ST_PEND : ST_IDLE;
            default: st_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            copy_l   <= 1'b0;
            rearm    <= 1'b0;
            bank     <= 1'b0;
            idx      <= '0;
            hold     <= 1'b0;
            dst_we   <= 1'b0;
            dst_addr <= '0;
        end else begin
            st     <= st_nx;
            copy_l <= obj_copy;

            if (st == ST_PEND && st_nx == ST_COPY) begin
                bank <= mixpsel;
                idx  <= '0;
            end else if (st == ST_COPY && !idx[AW]) begin
                idx <= idx + 1'b1;
            end

            if (st == ST_DONE)
                rearm <= 1'b0;
            else if (st == ST_COPY && req)
                rearm <= 1'b1;

            // stall persists through DONE once the CPU has collided
            if (st == ST_DONE)
                hold <= 1'b0;
            else if (st == ST_COPY && cpu_cs)
                hold <= 1'b1;

            // write stage trails the read issue by one cycle
            dst_we <= (st == ST_COPY) && !idx[AW];
            if ((st == ST_COPY) && !idx[AW])
                dst_addr <= {bank, idx[AW-1:0]};
        end
    end

    // read port arbitration
    always_comb begin
        src_addr = cpu_addr;
        if (st == ST_COPY)
            src_addr = idx[AW-1:0];
    end

    assign dst_din  = dst_we ? src_dout : 16'd0;
    assign cpu_busy = ((st == ST_COPY) && cpu_cs) || hold;
    assign dma_busy = (st == ST_PEND) || (st == ST_COPY);
    assign dma_done = (st == ST_DONE);

endmodule

// File: tb/tb_jtcop_objdma.sv
module tb_jtcop_objdma;
    import jtcop_pkg::*;

    localparam int AW  = OBJDMA_AW;
    localparam int LEN = OBJDMA_LEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          LVBL = 1'b1;
    logic          obj_copy = 1'b0;
    logic          mixpsel = 1'b0;
    logic          cpu_cs = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_busy;
    logic [AW-1:0] src_addr;
    logic [15:0]   src_dout;
    logic [AW:0]   dst_addr;
    logic [15:0]   dst_din;
    logic          dst_we;
    logic          dma_busy;
    logic          dma_done;

    always #5 clk = ~clk;

    jtcop_objdma #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .obj_copy(obj_copy),
        .mixpsel(mixpsel), .cpu_cs(cpu_cs), .cpu_addr(cpu_addr),
        .cpu_busy(cpu_busy), .src_addr(src_addr), .src_dout(src_dout),
        .dst_addr(dst_addr), .dst_din(dst_din), .dst_we(dst_we),
        .dma_busy(dma_busy), .dma_done(dma_done)
    );

    // object RAM with one cycle read latency
    logic [15:0] mem [LEN];
    always @(posedge clk) src_dout <= mem[src_addr];

    // captured object buffer
    logic [15:0] bufm [2*LEN];
    int          wcnt [2*LEN];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference schedule: each copy = accept cycle and first COPY cycle
    typedef struct { int pend; int start; } copy_t;
    copy_t cps[$];
    int    strobes[$];
    int    cs_from = -1, cs_to = -2;
    bit    cs_rand = 0;
    int    lvbl_fall = 1 << 30;
    bit    mix_rand = 0;
    bit    mix_val = 0;
    bit    mixhist [16384];
    int    hold_until = -1;
    int    done_seen = 0;

    int          bad  [7];
    int          fcyc [7];
    logic [63:0] fact [7];
    logic [63:0] fexp [7];
    string nm [7] = '{"src_addr", "dst_we", "dst_addr", "dst_din",
                      "dma_busy", "dma_done", "cpu_busy"};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void tally(input int i, input logic [63:0] a, input logic [63:0] e);
        if (a !== e) begin
            if (bad[i] == 0) begin
                fcyc[i] = cyc; fact[i] = a; fexp[i] = e;
            end
            bad[i]++;
        end
    endfunction

    task automatic report(input string tag);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bad[i] != 0) begin
                errors++;
                $display("FAIL %s_%s: %0d bad cycles, first at cycle %0d got %0h expected %0h",
                         tag, nm[i], bad[i], fcyc[i], fact[i], fexp[i]);
            end
            bad[i] = 0;
        end
    endtask

    // per-cycle expectation from the copy schedule
    function automatic void eval();
        int            k = cyc;
        logic          chk_src = 1'b1;
        logic [AW-1:0] esrc = cpu_addr;
        logic          ebusy = 0, ewe = 0, edone = 0, incopy = 0, ecb;
        logic [AW:0]   eaddr = '0;
        logic [15:0]   edin = '0;
        logic [AW-1:0] n;
        int            cend = 0;
        foreach (cps[i]) begin
            if (k >= cps[i].pend && k <= cps[i].start + LEN) ebusy = 1;
            if (k >= cps[i].start && k <= cps[i].start + LEN) begin
                incopy = 1;
                cend = cps[i].start + LEN + 1;
                if (k < cps[i].start + LEN) esrc = AW'(k - cps[i].start);
                else chk_src = 0;
            end
            if (k > cps[i].start && k <= cps[i].start + LEN) begin
                ewe = 1;
                n = AW'(k - cps[i].start - 1);
                eaddr = {mixhist[cps[i].start - 1], n};
                edin = mem[n];
            end
            if (k == cps[i].start + LEN + 1) edone = 1;
        end
        ecb = (incopy && cpu_cs) || (k <= hold_until);
        if (incopy && cpu_cs) hold_until = cend;
        if (chk_src) tally(0, src_addr, esrc);
        tally(1, dst_we, ewe);
        if (ewe) begin
            tally(2, dst_addr, eaddr);
            tally(3, dst_din, edin);
        end
        tally(4, dma_busy, ebusy);
        tally(5, dma_done, edone);
        tally(6, cpu_busy, ecb);
        if (dma_done === 1'b1) done_seen++;
        if (dst_we === 1'b1) begin
            bufm[dst_addr] = dst_din;
            wcnt[dst_addr]++;
        end
    endfunction

    task automatic step_drive();
        bit s = 0;
        @(posedge clk);
        cyc++;
        #1;
        foreach (strobes[i]) if (cyc >= strobes[i] && cyc <= strobes[i] + 2) s = 1;
        obj_copy = s;
        cpu_cs   = cs_rand ? ($urandom % 4 == 0) : (cyc >= cs_from && cyc <= cs_to);
        cpu_addr = AW'($urandom);
        LVBL     = (cyc < lvbl_fall);
        mixpsel  = mix_rand ? 1'($urandom) : mix_val;
        mixhist[cyc] = mixpsel;
    endtask

    task automatic run_until(input int last);
        while (cyc < last) begin
            step_drive();
            @(negedge clk);
            eval();
        end
    endtask

    task automatic check_buf(input string tag);
        logic [15:0] eb [2*LEN];
        int          ec [2*LEN];
        int          bc = 0, bn = 0;
        logic [AW:0] a;
        for (int i = 0; i < 2*LEN; i++) begin eb[i] = '0; ec[i] = 0; end
        foreach (cps[i])
            for (int n = 0; n < LEN; n++) begin
                a = {mixhist[cps[i].start - 1], AW'(n)};
                eb[a] = mem[n];
                ec[a]++;
            end
        for (int i = 0; i < 2*LEN; i++) begin
            if (ec[i] != wcnt[i]) bn++;
            if (ec[i] > 0 && bufm[i] !== eb[i]) bc++;
        end
        check({tag, "_buf_data_bad_words"}, bc, 0);
        check({tag, "_buf_write_count_bad"}, bn, 0);
        check({tag, "_done_pulses"}, done_seen, cps.size());
    endtask

    task automatic new_test();
        cps.delete();
        strobes.delete();
        hold_until = -1;
        done_seen = 0;
        cs_from = -1; cs_to = -2;
        for (int i = 0; i < 2*LEN; i++) wcnt[i] = 0;
    endtask

    typedef struct {
        logic          cs;
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_src;
        logic          exp_cbusy;
        logic          exp_dbusy;
    } vec_t;
    vec_t vt [6];

    initial begin
        int s, c, c2;
        for (int i = 0; i < 2*LEN; i++) begin bufm[i] = '0; wcnt[i] = 0; end
        for (int i = 0; i < 6; i++) begin
            vt[i].cs        = (i % 2 == 1);
            vt[i].addr      = AW'($urandom);
            vt[i].exp_src   = vt[i].addr;
            vt[i].exp_cbusy = 1'b0;
            vt[i].exp_dbusy = 1'b0;
        end
        vt[4].addr = '1; vt[4].exp_src = '1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dma_busy", dma_busy, 0);
        check("rst_dma_done", dma_done, 0);
        check("rst_dst_we",   dst_we,   0);
        check("rst_cpu_busy", cpu_busy, 0);
        check("rst_dst_addr", dst_addr, 0);
        check("rst_dst_din",  dst_din,  0);
        check("rst_src_addr", src_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // idle arbitration vectors
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); cyc++; #1;
            cpu_cs = vt[i].cs; cpu_addr = vt[i].addr;
            @(negedge clk);
            check($sformatf("vec%0d_src_addr", i), src_addr, vt[i].exp_src);
            check($sformatf("vec%0d_cpu_busy", i), cpu_busy, vt[i].exp_cbusy);
            check($sformatf("vec%0d_dma_busy", i), dma_busy, vt[i].exp_dbusy);
            check($sformatf("vec%0d_dma_done", i), dma_done, 0);
        end

        // A: held strobe, LVBL high at request, bank 0, data = ~addr
        new_test();
        for (int i = 0; i < LEN; i++) mem[i] = ~16'(i);
        mix_rand = 0; mix_val = 0;
        s = cyc + 2;
        strobes.push_back(s);
        lvbl_fall = s + 6;
`ifdef JTCOP_OBJDMA_VBLANK_EN
        c = s + 7;
`else
        c = s + 2;
`endif
        cps.push_back('{s + 1, c});
        run_until(c + LEN + 6);
        report("A");
        check_buf("A");

        // B: bank 1, random data, CPU collision at word 100, re-arm at word 500
        new_test();
        for (int i = 0; i < LEN; i++) mem[i] = 16'($urandom);
        mix_val = 1; lvbl_fall = 0;
        s = cyc + 3; c = s + 2; c2 = c + LEN + 3;
        cs_from = c + 100; cs_to = c + 100;
        strobes.push_back(s);
        strobes.push_back(c + 500);
        cps.push_back('{s + 1, c});
        cps.push_back('{c + LEN + 2, c2});
        run_until(c2 + LEN + 6);
        report("B");
        check_buf("B");

        // C: reset in the middle of a copy
        new_test();
        mix_rand = 1; cs_rand = 1;
        s = cyc + 2; c = s + 2;
        strobes.push_back(s);
        cps.push_back('{s + 1, c});
        run_until(c + 299);
        report("C");
        @(posedge clk); cyc++; #1;
        rst_n = 1'b0; obj_copy = 1'b0; cpu_cs = 1'b1; cpu_addr = AW'($urandom);
        @(negedge clk);
        check("C_reset_dma_busy", dma_busy, 0);
        check("C_reset_dst_we",   dst_we,   0);
        check("C_reset_dma_done", dma_done, 0);
        check("C_reset_cpu_busy", cpu_busy, 0);
        check("C_reset_dst_addr", dst_addr, 0);
        check("C_reset_src_addr", src_addr, cpu_addr);
        @(posedge clk); cyc++; #1 rst_n = 1'b1;

        // D: copy after reset, second request lands exactly on DONE
        new_test();
        for (int i = 0; i < LEN; i++) mem[i] = 16'($urandom);
        s = cyc + 3; c = s + 2; c2 = c + LEN + 3;
        strobes.push_back(s);
        strobes.push_back(c + LEN + 1);
        cps.push_back('{s + 1, c});
        cps.push_back('{c + LEN + 2, c2});
        run_until(c2 + LEN + 6);
        report("D");
        check_buf("D");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
